pipe_stage_reg: RTL and testbench

//  Generic parametrised pipeline register for stage boundaries (IF/ID, ID/EX, EX/MEM, MEM/WB).

---
 rtl/pipe_stage_reg.sv | 108 ++++++++++
 tb/tb_pipe_stage_reg.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - valid/ready pipeline stage register with flush.
// Define PIPE_SKID_EN for the two-entry skid build with a registered in_ready.
module pipe_stage_reg #(
  parameter int                 DATA_W    = 101,
  parameter logic [DATA_W-1:0]  RESET_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
);

  logic              accept;
  logic              handoff;
  logic              main_valid_q, main_valid_d;
  logic [DATA_W-1:0] main_q, main_d;

  assign accept    = in_valid & in_ready;
  assign handoff   = main_valid_q & out_ready;
  assign out_valid = main_valid_q;
  assign out_data  = main_q;

`ifdef PIPE_SKID_EN
  logic              skid_valid_q, skid_valid_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              in_ready_q;

  // in_ready comes straight from a flop, so out_ready never reaches it combinationally.
  assign in_ready = in_ready_q;

  always_comb begin
    main_valid_d = main_valid_q;
    main_d       = main_q;
    skid_valid_d = skid_valid_q;
    skid_d       = skid_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (skid_valid_q) begin
      if (handoff) begin
        main_d       = skid_q;
        skid_valid_d = 1'b0;
      end
    end else if (main_valid_q) begin
      if (handoff) begin
        if (accept) begin
          main_d = in_data;
        end else begin
          main_valid_d = 1'b0;
        end
      end else if (accept) begin
        skid_d       = in_data;
        skid_valid_d = 1'b1;
      end
    end else if (accept) begin
      main_d       = in_data;
      main_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_valid_q <= 1'b0;
      main_q       <= RESET_VAL;
      skid_valid_q <= 1'b0;
      skid_q       <= RESET_VAL;
      in_ready_q   <= 1'b1;
    end else begin
      main_valid_q <= main_valid_d;
      main_q       <= main_d;
      skid_valid_q <= skid_valid_d;
      skid_q       <= skid_d;
      in_ready_q   <= !skid_valid_d;
    end
  end
`else
  assign in_ready = !main_valid_q | out_ready;

  always_comb begin
    main_valid_d = main_valid_q;
    main_d       = main_q;
    if (flush) begin
      main_valid_d = 1'b0;
    end else if (accept) begin
      main_d       = in_data;
      main_valid_d = 1'b1;
    end else if (handoff) begin
      main_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_valid_q <= 1'b0;
      main_q       <= RESET_VAL;
    end else begin
      main_valid_q <= main_valid_d;
      main_q       <= main_d;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - scoreboard bench for pipe_stage_reg (either build).
module tb_pipe_stage_reg;
  localparam int            W  = 101;
  localparam logic [W-1:0]  RV = 101'h3C;
`ifdef PIPE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0] in_data, out_data;

  logic [W-1:0] exp_q[$];
  logic         exp_ready_c;
  int           checks = 0;
  int           errors = 0;

  pipe_stage_reg #(.DATA_W(W), .RESET_VAL(RV)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: the expected queue holds exactly the beats the stage should be holding.
  initial begin : monitor
    logic         have_prev, prev_v, prev_r, exp_v;
    logic [W-1:0] prev_data;
    have_prev = 1'b0;
    prev_v = 1'b0;
    prev_r = 1'b0;
    prev_data = '0;
    forever begin
      @(negedge clk);
      exp_v       = exp_q.size() > 0;
      exp_ready_c = SKID ? (exp_q.size() < 2) : (exp_q.size() == 0 || out_ready);
      chk("out_valid", {100'd0, out_valid}, {100'd0, exp_v});
      chk("in_ready", {100'd0, in_ready}, {100'd0, exp_ready_c});
      if (rst) begin
        have_prev = 1'b0;
      end else begin
        if (have_prev && (!out_valid || (prev_v && !prev_r)))
          chk("hold", out_data, prev_data);
        if (exp_v) begin
          chk("out_data", out_data, exp_q[0]);
          if (out_ready) void'(exp_q.pop_front());
        end
        have_prev = 1'b1;
        prev_v    = out_valid;
        prev_r    = out_ready;
        prev_data = out_data;
      end
    end
  end

  // One cycle of stimulus; the accepted beat (if any) is pushed as an expected output.
  task automatic step(input logic v, input logic [W-1:0] d, input logic ordy, input logic fl);
    @(posedge clk);
    #1;
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    @(negedge clk);
    #2;
    if (flush) exp_q.delete();
    else if (in_valid && exp_ready_c && !rst) exp_q.push_back(in_data);
  endtask

  task automatic async_reset();
    #1;
    rst = 1'b1;
    exp_q.delete();
    in_valid = 1'b0;
    flush = 1'b0;
    #1;
    chk("rst_out_valid", {100'd0, out_valid}, '0);
    chk("rst_out_data", out_data, RV);
    chk("rst_in_ready", {100'd0, in_ready}, 101'd1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin : driver
    logic [W-1:0] d;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    #1;
    chk("init_out_valid", {100'd0, out_valid}, '0);
    chk("init_out_data", out_data, RV);
    chk("init_in_ready", {100'd0, in_ready}, 101'd1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Streaming with out_ready held high
    step(1'b1, 101'h1, 1'b1, 1'b0);
    step(1'b1, 101'h2, 1'b1, 1'b0);
    chk("t1_data1", out_data, 101'h1);
    step(1'b1, 101'h3, 1'b1, 1'b0);
    chk("t1_data2", out_data, 101'h2);
    step(1'b0, '0, 1'b1, 1'b0);
    chk("t1_data3", out_data, 101'h3);
    step(1'b0, '0, 1'b1, 1'b0);

    // Downstream stall
    step(1'b1, 101'h11, 1'b0, 1'b0);
    step(1'b1, 101'h22, 1'b0, 1'b0);
    step(1'b1, 101'h22, 1'b0, 1'b0);
    chk("t2_in_ready", {100'd0, in_ready}, '0);
    chk("t2_data_held", out_data, 101'h11);
    step(1'b1, 101'h22, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    chk("t2_second", out_data, 101'h22);
    step(1'b0, '0, 1'b1, 1'b0);

    // Flush with an incoming beat while stalled (FULL in the skid build)
    step(1'b1, 101'h44, 1'b0, 1'b0);
    step(1'b1, 101'h55, 1'b0, 1'b0);
    step(1'b1, 101'h33, 1'b0, 1'b1);
    step(1'b0, '0, 1'b1, 1'b0);
    chk("t3_valid", {100'd0, out_valid}, '0);
    chk("t3_ready", {100'd0, in_ready}, 101'd1);
    chk("t3_payload_kept", out_data, 101'h44);
    step(1'b1, 101'h66, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    chk("t3_after", out_data, 101'h66);
    step(1'b0, '0, 1'b1, 1'b0);

    // Async reset during a stall
    step(1'b1, 101'hA5, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    chk("t4_before", out_data, 101'hA5);
    async_reset();
    step(1'b1, 101'h77, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    chk("t4_latency", out_data, 101'h77);
    chk("t4_valid", {100'd0, out_valid}, 101'd1);

    // Random valid/ready/flush traffic
    for (int i = 0; i < 400; i++) begin
      d = {5'd0, $urandom(), $urandom(), $urandom()};
      d[15:0] = 16'(i + 16'h100);
      step(1'($urandom_range(0, 1)), d, 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 31) == 0));
    end
    repeat (3) step(1'b0, '0, 1'b1, 1'b0);
    chk("drain_valid", {100'd0, out_valid}, '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
